// File: rtl/riscv_io_pkg.sv
// Shared register map, STATUS bit positions and transmitter state encoding for
// the memory-mapped UART transmitter.
package riscv_io_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_PAR   = 4;
    localparam int ST_CNT   = 8;

    localparam logic [15:0] DIV_MIN = 16'd2;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

    // A divisor of 0 or 1 would leave the baud counter with no time to reload.
    function automatic logic [15:0] clamp_div(input logic [15:0] v);
        return (v < DIV_MIN) ? DIV_MIN : v;
    endfunction

endpackage

// File: rtl/io_fifo.sv
// Synchronous byte FIFO; a push while full is accepted only when a pop frees
// the slot in the same cycle, and a pop while empty is ignored.
module io_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop & (count_q != '0);
        do_push  = push & ((count_q != FULL_CNT) | do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) count_d = count_q + 1'b1;
        if (do_pop && !do_push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign count    = count_q;

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter sitting between the CPU data port and SRAM port 1.
// Define UART_TX_PARITY_EN to add an even-parity bit between the data bits and stop.
module uart_tx_mmio
    import riscv_io_pkg::*;
#(
    parameter logic [29:0] BASE_WADDR = 30'h3FFF_FF00,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] cpu_addr,
    input  logic        cpu_write,
    input  logic [31:0] cpu_wdata,
    input  logic [31:0] ram_rdata,
    output logic        ram_write,
    output logic [31:0] cpu_rdata,
    output logic        tx,
    output logic        irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic            hit, hit_q;
    logic [1:0]      off;
    logic            wr_hit, push, pop, busy;
    logic [31:0]     status, io_rdata_d, io_rdata_q;
    logic [15:0]     div_d, div_q;
    logic            ovf_d, ovf_q;
    logic            fifo_full, fifo_empty;
    logic [7:0]      fifo_data;
    logic [CW-1:0]   fifo_count;
    logic            unused_wdata;

    tx_state_t       state_q;
    logic            tx_q;
    logic [7:0]      shift_q;
    logic [2:0]      bit_cnt_q;
    logic [15:0]     baud_cnt_q;
`ifdef UART_TX_PARITY_EN
    logic            parity_q;
`endif

    assign hit          = (cpu_addr[29:2] == BASE_WADDR[29:2]);
    assign off          = cpu_addr[1:0];
    assign wr_hit       = cpu_write & hit;
    assign ram_write    = cpu_write & ~hit;
    assign push         = wr_hit & (off == REG_DATA);
    assign pop          = (state_q == IDLE) & ~fifo_empty;
    assign busy         = (state_q != IDLE);
    assign unused_wdata = ^cpu_wdata[31:16];

    io_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (cpu_wdata[7:0]),
        .pop       (pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        status           = '0;
        status[ST_FULL]  = fifo_full;
        status[ST_EMPTY] = fifo_empty;
        status[ST_BUSY]  = busy;
        status[ST_OVF]   = ovf_q;
`ifdef UART_TX_PARITY_EN
        status[ST_PAR]   = 1'b1;
`endif
        status[ST_CNT +: CW] = fifo_count;

        io_rdata_d = '0;
        if (hit) begin
            case (off)
                REG_STATUS: io_rdata_d = status;
                REG_DIV:    io_rdata_d = {16'h0000, div_q};
                default:    io_rdata_d = '0;
            endcase
        end

        div_d = div_q;
        if (wr_hit && off == REG_DIV) div_d = clamp_div(cpu_wdata[15:0]);

        // A same-cycle pop makes room, so only a push that finds no free slot is lost.
        ovf_d = ovf_q;
        if (wr_hit && off == REG_STATUS && cpu_wdata[ST_OVF]) ovf_d = 1'b0;
        if (push && fifo_full && !pop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q      <= 1'b0;
            io_rdata_q <= '0;
            div_q      <= DIV_RESET;
            ovf_q      <= 1'b0;
        end else begin
            hit_q      <= hit;
            io_rdata_q <= io_rdata_d;
            div_q      <= div_d;
            ovf_q      <= ovf_d;
        end
    end

    // Each bit lasts div_q cycles; the divisor is sampled only when a bit begins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tx_q       <= 1'b1;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            baud_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (!fifo_empty) begin
                        shift_q    <= fifo_data;
`ifdef UART_TX_PARITY_EN
                        parity_q   <= ^fifo_data;
`endif
                        bit_cnt_q  <= '0;
                        baud_cnt_q <= div_q;
                        tx_q       <= 1'b0;
                        state_q    <= START;
                    end
                end
                START: begin
                    if (baud_cnt_q == 16'd1) begin
                        baud_cnt_q <= div_q;
                        tx_q       <= shift_q[0];
                        state_q    <= DATA;
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 16'd1;
                    end
                end
                DATA: begin
                    if (baud_cnt_q == 16'd1) begin
                        baud_cnt_q <= div_q;
                        if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx_q    <= parity_q;
                            state_q <= PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= STOP;
`endif
                        end else begin
                            shift_q   <= {1'b0, shift_q[7:1]};
                            tx_q      <= shift_q[1];
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 16'd1;
                    end
                end
                PARITY: begin
                    if (baud_cnt_q == 16'd1) begin
                        baud_cnt_q <= div_q;
                        tx_q       <= 1'b1;
                        state_q    <= STOP;
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 16'd1;
                    end
                end
                STOP: begin
                    if (baud_cnt_q == 16'd1) begin
                        tx_q    <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 16'd1;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx        = tx_q;
    assign irq       = fifo_empty & ~busy;
    assign cpu_rdata = hit_q ? io_rdata_q : ram_rdata;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Randomized scoreboard bench for uart_tx_mmio: reads and serial frames are
// queued as expectations and checked by independent monitors.
`timescale 1ns/1ps
module tb_uart_tx_mmio;

    localparam logic [29:0] A_DATA = 30'h3FFF_FF00;
    localparam logic [29:0] A_STAT = 30'h3FFF_FF01;
    localparam logic [29:0] A_DIV  = 30'h3FFF_FF02;
    localparam logic [29:0] A_RSV  = 30'h3FFF_FF03;
    localparam logic [29:0] A_BELOW = 30'h3FFF_FEFF;
    localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
    localparam logic [31:0] PAR_FLAG = 32'h10;
`else
    localparam int NBITS = 10;
    localparam logic [31:0] PAR_FLAG = 32'h0;
`endif
    localparam int WAIT_LIM = 20000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [29:0] cpu_addr = 30'd5;
    logic        cpu_write = 1'b0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] ram_rdata = '0;
    logic        ram_write;
    logic [31:0] cpu_rdata;
    logic        tx, irq;

    always #5 clk = ~clk;

    uart_tx_mmio #(
        .BASE_WADDR (30'h3FFF_FF00),
        .FIFO_DEPTH (DEPTH),
        .DIV_RESET  (16'd434)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_write (cpu_write),
        .cpu_wdata (cpu_wdata),
        .ram_rdata (ram_rdata),
        .ram_write (ram_write),
        .cpu_rdata (cpu_rdata),
        .tx        (tx),
        .irq       (irq)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // SRAM port-1 model: registered read, read-before-write.
    logic [31:0] mem [logic [29:0]];
    always @(posedge clk) begin
        ram_rdata <= mem.exists(cpu_addr) ? mem[cpu_addr] : 32'h0;
        if (ram_write) mem[cpu_addr] = cpu_wdata;
    end

    // Read scoreboard: one expected word per read address issued.
    logic [31:0] rd_exp_q[$];
    string       rd_name_q[$];
    logic        rd_pend = 1'b0;
    logic        rd_pend_q = 1'b0;
    always @(posedge clk) rd_pend_q <= rd_pend;
    always @(negedge clk) begin
        if (rd_pend_q) begin
            if (rd_exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL rd_scoreboard: got 0x%08h expected no read pending", cpu_rdata);
            end else begin
                check(rd_name_q.pop_front(), cpu_rdata, rd_exp_q.pop_front());
            end
        end
    end

    // Serial monitor: every cycle of a frame must carry the expected bit value.
    logic [7:0] exp_tx_q[$];
    int   cur_div = 434;
    bit   mon_active = 0;
    int   mon_bit = 0, mon_cyc = 0, mon_div = 0, frames_done = 0;
    logic [7:0] mon_byte = '0;
    bit   mon_bad = 0;
    int   bad_bit = 0;

    function automatic logic exp_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (idx == NBITS - 1) return 1'b1;
        return ^b;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            mon_active = 0;
        end else begin
            if (!mon_active && tx === 1'b0) begin
                mon_active = 1;
                mon_bit = 0;
                mon_cyc = 0;
                mon_div = cur_div;
                mon_bad = 0;
                if (exp_tx_q.size() == 0) begin
                    mon_byte = '0;
                    mon_bad = 1;
                    bad_bit = -1;
                end else begin
                    mon_byte = exp_tx_q.pop_front();
                end
            end
            if (mon_active) begin
                if (tx !== exp_bit(mon_byte, mon_bit) && !mon_bad) begin
                    mon_bad = 1;
                    bad_bit = mon_bit;
                end
                mon_cyc++;
                if (mon_cyc == mon_div) begin
                    mon_cyc = 0;
                    mon_bit++;
                    if (mon_bit == NBITS) begin
                        mon_active = 0;
                        frames_done++;
                        vectors++;
                        if (mon_bad) begin
                            miscompares++;
                            $display("FAIL tx_frame: byte 0x%02h wrong at frame bit %0d (-1 = no frame expected)",
                                     mon_byte, bad_bit);
                        end
                    end
                end
            end
        end
    end

    function automatic logic [31:0] st(input bit full, input bit empty, input bit busy,
                                       input bit ovf, input int cnt);
        logic [31:0] v;
        v = PAR_FLAG;
        v[0] = full;
        v[1] = empty;
        v[2] = busy;
        v[3] = ovf;
        v[11:8] = cnt[3:0];
        return v;
    endfunction

    task automatic idle_cyc();
        @(posedge clk); #1;
        cpu_addr = 30'h10;
        cpu_write = 1'b0;
        rd_pend = 1'b0;
    endtask

    task automatic wr(input logic [29:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        cpu_addr = a;
        cpu_write = 1'b1;
        cpu_wdata = d;
        rd_pend = 1'b0;
    endtask

    task automatic rd(input logic [29:0] a, input logic [31:0] e, input string n);
        @(posedge clk); #1;
        cpu_addr = a;
        cpu_write = 1'b0;
        rd_pend = 1'b1;
        rd_exp_q.push_back(e);
        rd_name_q.push_back(n);
    endtask

    task automatic push_byte(input logic [7:0] b);
        wr(A_DATA, {8'($urandom), 8'($urandom), 8'($urandom), b});
        exp_tx_q.push_back(b);
    endtask

    task automatic wait_idle(input string n);
        int c;
        c = 0;
        do begin
            idle_cyc();
            c++;
        end while (!(irq === 1'b1 && !mon_active) && c < WAIT_LIM);
        check({n, "_idle_reached"}, 32'(c < WAIT_LIM), 32'd1);
        check({n, "_frames_left"}, 32'(exp_tx_q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, n, dv, fd0;
        logic [7:0] b;
        logic [29:0] a;

        mem[30'd5] = 32'hDEAD_BEEF;
        mem[A_DATA] = 32'hCAFE_F00D;
        repeat (3) @(posedge clk);
        #2;
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_irq", 32'(irq), 32'd1);
        check("reset_rdata_bypass", cpu_rdata, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        rst = 1'b0;

        rd(A_STAT, st(0, 1, 0, 0, 0), "status_after_reset");
        rd(A_DIV, 32'd434, "div_after_reset");
        rd(A_RSV, 32'd0, "reserved_read");
        rd(A_DATA, 32'd0, "data_read");
        wr(A_RSV, $urandom);
        rd(A_RSV, 32'd0, "reserved_after_write");
        wr(A_DIV, 32'd1);
        rd(A_DIV, 32'd2, "div_clamp_1");
        wr(A_DIV, 32'd0);
        rd(A_DIV, 32'd2, "div_clamp_0");
        wr(A_DIV, 32'hABCD_0004);
        cur_div = 4;
        rd(A_DIV, 32'd4, "div_4");

        push_byte(8'h55);
        #1;
        check("ram_write_window", 32'(ram_write), 32'd0);
        rd(A_STAT, st(0, 0, 0, 0, 1), "status_one_queued");
        rd(A_STAT, st(0, 1, 1, 0, 0), "status_busy");
        wait_idle("frame_55");
        check("sram_window_untouched", mem[A_DATA], 32'hCAFE_F00D);

        wr(A_BELOW, 32'h1234_5678);
        #1;
        check("ram_write_below", 32'(ram_write), 32'd1);
        idle_cyc();
        check("sram_below_written", mem.exists(A_BELOW) ? mem[A_BELOW] : 32'h0, 32'h1234_5678);

        rd(30'd5, 32'hDEAD_BEEF, "sram_read");
        rd(A_STAT, st(0, 1, 0, 0, 0), "status_after_sram_read");
        idle_cyc();

        push_byte(8'h07);
        push_byte(8'hA5);
        wait_idle("frames_07_a5");

        for (int r = 0; r < 6; r++) begin
            dv = $urandom_range(0, 6);
            wr(A_DIV, 32'(dv));
            cur_div = (dv < 2) ? 2 : dv;
            rd(A_DIV, 32'(cur_div), "div_random");
            n = $urandom_range(1, 5);
            for (int k = 0; k < n; k++) begin
                b = 8'($urandom);
                push_byte(b);
            end
            wait_idle("random_burst");
            rd(A_STAT, st(0, 1, 0, 0, 0), "status_after_burst");
            a = 30'($urandom_range(8, 40));
            mem[a] = $urandom;
            rd(a, mem[a], "sram_random_read");
            idle_cyc();
        end

        wr(A_DIV, 32'd100);
        cur_div = 100;
        fd0 = frames_done;
        for (int k = 0; k < DEPTH + 1; k++) begin
            b = 8'($urandom);
            push_byte(b);
        end
        rd(A_STAT, st(1, 0, 1, 0, DEPTH), "status_full");
        wr(A_DATA, 32'h0000_00EE);
        rd(A_STAT, st(1, 0, 1, 1, DEPTH), "status_overflow");
        wr(A_STAT, 32'h0000_0008);
        rd(A_STAT, st(1, 0, 1, 0, DEPTH), "status_overflow_cleared");
        idle_cyc();

        c = 0;
        while (!(frames_done >= fd0 + 2 && mon_active && mon_bit == 4) && c < WAIT_LIM) begin
            idle_cyc();
            c++;
        end
        check("reach_data_bit3", 32'(c < WAIT_LIM), 32'd1);
        rst = 1'b1;
        exp_tx_q.delete();
        #1;
        check("midframe_reset_tx", 32'(tx), 32'd1);
        check("midframe_reset_irq", 32'(irq), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        cur_div = 434;
        rd(A_STAT, st(0, 1, 0, 0, 0), "status_after_midframe_reset");
        rd(A_DIV, 32'd434, "div_after_midframe_reset");
        repeat (20) idle_cyc();
        check("tx_idle_after_reset", 32'(tx), 32'd1);
        check("frames_left_after_reset", 32'(exp_tx_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
